// File: rtl/rx_pkg.sv
// Shared types and constants for the receive bank buffer.
package rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_FILL,
    ST_CLOSE
  } rx_state_e;

  localparam logic [7:0] UNSYNC_FILL    = 8'hFF;
  localparam int         LEN_OFFSET_DEF = 40;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_bank_ram.sv
// Simple dual-port RAM: DATA_W write port, RD_W read port (little-endian byte lanes).
// Write takes effect at the clock edge; read data appears one cycle after rd_en_i.
module rx_bank_ram
  import rx_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int RD_W   = 32,
  parameter  int WR_AW  = 10,
  localparam int LANES  = RD_W / DATA_W,
  localparam int LANE_BW = clog2(LANES),
  localparam int RD_AW  = WR_AW - LANE_BW
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [WR_AW-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  input  logic              rd_en_i,
  input  logic [RD_AW-1:0]  rd_addr_i,
  output logic [RD_W-1:0]   rd_dat_o
);
  localparam int LSB_W = (LANE_BW > 0) ? LANE_BW : 1;

  logic [LANES-1:0][DATA_W-1:0] mem_q [1 << RD_AW];
  logic [RD_W-1:0]              rd_dat_q;
  logic [RD_AW-1:0]             wr_word;
  logic [LSB_W-1:0]             wr_lane;

  assign wr_word = RD_AW'(wr_addr_i >> LANE_BW);
  assign wr_lane = LSB_W'(wr_addr_i % LANES);

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_word][wr_lane] <= wr_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/rx_bank_buffer.sv
// Multi-bank receive frame buffer: TOA header + payload per slot, 0xFF fill on unsync timeout.
// RAM write lands one cycle after acceptance, reads return one cycle later; no input stall, a full ring drops the frame.
module rx_bank_buffer
  import rx_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int BANK_NUM   = 2,
  parameter  int BANK_AW    = 9,
  parameter  int HDR_BYTES  = 4,
  parameter  int RD_W       = 32,
  parameter  int LEN_OFFSET = LEN_OFFSET_DEF,
  parameter  int IRQ_HOLD   = 399,
  localparam int BANK_BW    = clog2(BANK_NUM),
  localparam int RD_AW      = BANK_AW - clog2(RD_W / DATA_W)
) (
  input  logic               logic_clk_in,
  input  logic               logic_rst_n_in,
  input  logic               data_wr_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               toa_wr_in,
  input  logic [31:0]        slot_timer_in,
  input  logic [31:0]        unsync_timer_in,
  input  logic [1:0]         net_slot_mode,
  input  logic               tx_slot_interrupt,
  input  logic [8:0]         rx_slot_length,
  input  logic               ram_rd_in,
  input  logic [RD_AW-1:0]   addr_rd_in,
  output logic [RD_W-1:0]    ram_data_out,
  input  logic               bank_release_in,
  input  logic               overflow_clr_in,
  output logic               rx_slot_interrupt_out,
  output logic               rx_dsp_interrupt_out,
  output logic [BANK_BW-1:0] rd_bank_out,
  output logic [BANK_BW:0]   bank_full_cnt_out,
  output logic               overflow_out
);
  localparam int DEPTH  = 1 << BANK_AW;
  localparam int HOLD_W = clog2(IRQ_HOLD + 1);
  localparam int WR_AW  = BANK_BW + BANK_AW;

  rx_state_e          state_q;
  logic [BANK_AW-1:0] off_q, end_q;
  logic [31:0]        toa_q;
  logic [1:0]         mode_cur_q;
  logic               unsync_hit_q;
  logic [BANK_BW-1:0] wr_bank_q, rd_bank_q;
  logic [BANK_BW:0]   full_cnt_q;
  logic               ovf_q, slot_irq_q, dsp_irq_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               wr_en_q;
  logic [WR_AW-1:0]   wr_addr_q;
  logic [DATA_W-1:0]  wr_dat_q;

  int                 p_len;
  logic [BANK_AW-1:0] end_calc;
  logic               bank_full, frame_start, drop, commit, rel_ok;

  // Payload length saturates to the full bank when the slot length is unusable.
  always_comb begin
    p_len = int'(rx_slot_length) - LEN_OFFSET;
    if ((int'(rx_slot_length) <= LEN_OFFSET) || (HDR_BYTES + p_len > DEPTH)) begin
      p_len = DEPTH - HDR_BYTES;
    end
    end_calc = BANK_AW'(HDR_BYTES + p_len - 1);
  end

  assign bank_full   = (full_cnt_q == (BANK_BW + 1)'(BANK_NUM));
  assign frame_start = (state_q == ST_IDLE) && (unsync_hit_q || toa_wr_in);
  assign drop        = frame_start && bank_full;
  assign commit      = (state_q == ST_CLOSE);
  assign rel_ok      = bank_release_in && (full_cnt_q != '0);

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      mode_cur_q   <= 2'b00;
      unsync_hit_q <= 1'b0;
    end else begin
      if (tx_slot_interrupt) mode_cur_q <= net_slot_mode;
      unsync_hit_q <= (mode_cur_q != 2'b01) && (slot_timer_in == unsync_timer_in);
    end
  end

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      end_q     <= '0;
      toa_q     <= '0;
      wr_bank_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start && !bank_full) begin
            off_q   <= '0;
            end_q   <= end_calc;
            toa_q   <= slot_timer_in;
            state_q <= unsync_hit_q ? ST_FILL : ST_HDR;
          end
        end
        ST_HDR: begin
          if (unsync_hit_q) begin
            state_q <= ST_FILL;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {wr_bank_q, off_q};
            wr_dat_q  <= toa_q[31 -: DATA_W];
            toa_q     <= toa_q << DATA_W;
            off_q     <= off_q + 1'b1;
            if (off_q == BANK_AW'(HDR_BYTES - 1)) state_q <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (unsync_hit_q) begin
            state_q <= ST_FILL;
          end else if (data_wr_in) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {wr_bank_q, off_q};
            wr_dat_q  <= data_in;
            if (off_q == end_q) state_q <= ST_CLOSE;
            else                off_q   <= off_q + 1'b1;
          end
        end
        ST_FILL: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= {wr_bank_q, off_q};
          wr_dat_q  <= DATA_W'(UNSYNC_FILL);
          if (off_q == end_q) state_q <= ST_CLOSE;
          else                off_q   <= off_q + 1'b1;
        end
        ST_CLOSE: begin
          wr_bank_q <= wr_bank_q + 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A release coinciding with a commit leaves the count alone but moves the read side on.
  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      full_cnt_q <= '0;
      rd_bank_q  <= '0;
      slot_irq_q <= 1'b0;
      dsp_irq_q  <= 1'b0;
      hold_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      slot_irq_q <= commit;
      if (commit && !rel_ok)      full_cnt_q <= full_cnt_q + 1'b1;
      else if (!commit && rel_ok) full_cnt_q <= full_cnt_q - 1'b1;
      if (rel_ok) rd_bank_q <= rd_bank_q + 1'b1;
      if (commit) begin
        dsp_irq_q <= 1'b1;
        hold_q    <= HOLD_W'(IRQ_HOLD - 1);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end else begin
        dsp_irq_q <= 1'b0;
      end
      if (drop)                 ovf_q <= 1'b1;
      else if (overflow_clr_in) ovf_q <= 1'b0;
    end
  end

  rx_bank_ram #(
    .DATA_W (DATA_W),
    .RD_W   (RD_W),
    .WR_AW  (WR_AW)
  ) u_ram (
    .clk_i     (logic_clk_in),
    .rst_n_i   (logic_rst_n_in),
    .wr_en_i   (wr_en_q),
    .wr_addr_i (wr_addr_q),
    .wr_dat_i  (wr_dat_q),
    .rd_en_i   (ram_rd_in),
    .rd_addr_i ({rd_bank_q, addr_rd_in}),
    .rd_dat_o  (ram_data_out)
  );

  assign rx_slot_interrupt_out = slot_irq_q;
  assign rx_dsp_interrupt_out  = dsp_irq_q;
  assign rd_bank_out           = rd_bank_q;
  assign bank_full_cnt_out     = full_cnt_q;
  assign overflow_out          = ovf_q;

endmodule
